// File: rtl/dso_dm_pkg.sv
// ---------------------------------------------------------------------------
// dso_dm_pkg
//   Shared definitions for the DataMover MM2S readout block:
//   - reader FSM state encoding
//   - bit positions of the 72-bit DataMover command word
//   - INCR / EOF field values and the 16-byte stream beat size
//   - pack_cmd(): builds a 72-bit MM2S command from BTT, address and tag
// ---------------------------------------------------------------------------
package dso_dm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    FIN  = 2'd3
  } state_e;

  localparam int unsigned BEAT_BYTES = 16;   // 128-bit stream beat

  localparam int CMD_W        = 72;
  localparam int CMD_BTT_LSB  = 0;
  localparam int CMD_BTT_W    = 23;
  localparam int CMD_TYPE_BIT = 23;
  localparam int CMD_DSA_LSB  = 24;
  localparam int CMD_DSA_W    = 6;
  localparam int CMD_EOF_BIT  = 30;
  localparam int CMD_DRR_BIT  = 31;
  localparam int CMD_ADDR_LSB = 32;
  localparam int CMD_TAG_LSB  = 64;
  localparam int CMD_TAG_W    = 4;
  localparam int CMD_RSVD_LSB = 68;
  localparam int CMD_RSVD_W   = 4;

  localparam logic CMD_TYPE_INCR = 1'b1;
  localparam logic CMD_EOF_SET   = 1'b1;

  function automatic logic [CMD_W-1:0] pack_cmd(input logic [CMD_BTT_W-1:0] btt,
                                                input logic [31:0]          saddr,
                                                input logic [CMD_TAG_W-1:0] tag);
    logic [CMD_W-1:0] c;
    c                               = '0;
    c[CMD_BTT_LSB +: CMD_BTT_W]     = btt;
    c[CMD_TYPE_BIT]                 = CMD_TYPE_INCR;
    c[CMD_DSA_LSB +: CMD_DSA_W]     = '0;
    c[CMD_EOF_BIT]                  = CMD_EOF_SET;
    c[CMD_DRR_BIT]                  = 1'b0;
    c[CMD_ADDR_LSB +: 32]           = saddr;
    c[CMD_TAG_LSB +: CMD_TAG_W]     = tag;
    c[CMD_RSVD_LSB +: CMD_RSVD_W]   = '0;
    return c;
  endfunction

endpackage

// File: rtl/datamover_mm2s_reader.sv
// ---------------------------------------------------------------------------
// datamover_mm2s_reader
//   Reads a run of fixed-size blocks out of a DDR3 ring buffer through an
//   AXI DataMover MM2S channel and forwards the data beats to a consumer.
//   One command is outstanding at a time; the address walks the ring and
//   wraps from BUF_BASE+BUF_SIZE back to BUF_BASE.
//
// Parameters
//   BTT_BYTES  bytes per MM2S command (multiple of 16)
//   BUF_BASE   ring start byte address
//   BUF_SIZE   ring length in bytes (multiple of BTT_BYTES)
//
// Ports
//   axi_aclk, rst          clock, synchronous active-high reset
//   start/start_addr/num_cmds  launch pulse, first address, command count
//   abort                  level stop request (current command is drained)
//   axis_cmd_*             72-bit DataMover command stream (out)
//   axis_data_*            128-bit DataMover read data (in)
//   m_axis_*               128-bit sample stream to the consumer (out)
//   busy/done/err          status; err is sticky until rst
//   beats_out              consumer beats since the last accepted start
//
// Build option
//   MM2S_READER_STATUS_EN  adds the DataMover status stream (axis_sts_*);
//                          each command then completes only after both its
//                          final data beat and its status beat.
// ---------------------------------------------------------------------------
module datamover_mm2s_reader
  import dso_dm_pkg::*;
#(
  parameter int unsigned BTT_BYTES = 4096,
  parameter logic [31:0] BUF_BASE  = 32'h0000_0000,
  parameter logic [31:0] BUF_SIZE  = 32'h1000_0000
) (
  input  logic         axi_aclk,
  input  logic         rst,
  input  logic         start,
  input  logic [31:0]  start_addr,
  input  logic [15:0]  num_cmds,
  input  logic         abort,
  output logic         axis_cmd_tvalid,
  input  logic         axis_cmd_tready,
  output logic [71:0]  axis_cmd_tdata,
  input  logic         axis_data_tvalid,
  output logic         axis_data_tready,
  input  logic [127:0] axis_data_tdata,
  input  logic         axis_data_tlast,
  output logic         m_axis_tvalid,
  input  logic         m_axis_tready,
  output logic [127:0] m_axis_tdata,
  output logic         m_axis_tlast,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [31:0]  beats_out
`ifdef MM2S_READER_STATUS_EN
  ,
  input  logic         axis_sts_tvalid,
  output logic         axis_sts_tready,
  input  logic [7:0]   axis_sts_tdata
`endif
);

  localparam logic [18:0] LAST_BEAT = 19'(BTT_BYTES / BEAT_BYTES - 1);
  localparam logic [31:0] BTT_INC   = 32'(BTT_BYTES);
  localparam logic [31:0] RING_END  = BUF_BASE + BUF_SIZE;

  state_e      state_q;
  logic [31:0] addr_q, beats_q;
  logic [15:0] ncmd_q, cidx_q;
  logic [18:0] beat_q;
  logic        cmd_vld_q, busy_q, done_q, err_q, abort_q;

  logic        in_data, data_open, last_beat, last_cmd, stop_req;
  logic        beat_hs, fin_beat, data_exit, tlast_bad;
  logic [31:0] addr_inc, addr_d;

  assign in_data   = (state_q == DATA);
  assign last_beat = (beat_q == LAST_BEAT);
  assign last_cmd  = ((cidx_q + 16'd1) == ncmd_q);
  // abort may arrive on the very cycle of the final beat, so look at the
  // live input as well as the latched request
  assign stop_req  = abort | abort_q;
  assign addr_inc  = addr_q + BTT_INC;
  assign addr_d    = (addr_inc == RING_END) ? BUF_BASE : addr_inc;

`ifdef MM2S_READER_STATUS_EN
  logic fin_beat_q, sts_q, sts_hs, sts_bad;
  // once the final beat is through, the data path closes while the status
  // beat is awaited
  assign data_open       = in_data & ~fin_beat_q;
  assign sts_hs          = in_data & axis_sts_tvalid;
  assign sts_bad         = ~axis_sts_tdata[7] | (|axis_sts_tdata[6:4]);
  assign data_exit       = (fin_beat | fin_beat_q) & (sts_hs | sts_q);
  assign axis_sts_tready = ~rst;
`else
  assign data_open       = in_data;
  assign data_exit       = fin_beat;
`endif

  // zero-latency pass-through while in DATA; gated by rst so nothing is
  // offered before the first reset edge has settled the state register
  assign m_axis_tvalid    = data_open & axis_data_tvalid & ~rst;
  assign axis_data_tready = data_open & m_axis_tready & ~rst;
  assign m_axis_tdata     = axis_data_tdata;
  assign m_axis_tlast     = data_open & last_beat & (last_cmd | stop_req);

  assign beat_hs   = m_axis_tvalid & m_axis_tready;
  assign fin_beat  = beat_hs & last_beat;
  assign tlast_bad = beat_hs & (axis_data_tlast != last_beat);

  assign axis_cmd_tvalid = cmd_vld_q & ~rst;
  assign axis_cmd_tdata  = pack_cmd(23'(BTT_BYTES), addr_q, cidx_q[3:0]);
  assign busy            = busy_q & ~rst;
  assign done            = done_q & ~rst;
  assign err             = err_q & ~rst;
  assign beats_out       = beats_q;

  always_ff @(posedge axi_aclk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      beats_q   <= '0;
      ncmd_q    <= '0;
      cidx_q    <= '0;
      beat_q    <= '0;
      cmd_vld_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      abort_q   <= 1'b0;
`ifdef MM2S_READER_STATUS_EN
      fin_beat_q <= 1'b0;
      sts_q      <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (beat_hs)   beats_q <= beats_q + 32'd1;
      if (tlast_bad) err_q   <= 1'b1;

      case (state_q)
        IDLE: begin
          if (start) begin
            addr_q  <= start_addr;
            ncmd_q  <= num_cmds;
            cidx_q  <= '0;
            beat_q  <= '0;
            beats_q <= '0;
            abort_q <= 1'b0;
            busy_q  <= 1'b1;
            if (num_cmds == 16'd0) begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end else begin
              state_q   <= CMD;
              cmd_vld_q <= 1'b1;
            end
          end
        end

        CMD: begin
          // a command that handshakes is owed its data even if abort is
          // seen on the same cycle, so it is drained before finishing
          if (axis_cmd_tready) begin
            cmd_vld_q <= 1'b0;
            state_q   <= DATA;
            if (abort) abort_q <= 1'b1;
          end else if (abort) begin
            cmd_vld_q <= 1'b0;
            state_q   <= FIN;
            done_q    <= 1'b1;
          end
        end

        DATA: begin
          if (abort)   abort_q <= 1'b1;
          if (beat_hs) beat_q  <= last_beat ? 19'd0 : beat_q + 19'd1;
`ifdef MM2S_READER_STATUS_EN
          if (fin_beat) fin_beat_q <= 1'b1;
          if (sts_hs) begin
            sts_q <= 1'b1;
            if (sts_bad) err_q <= 1'b1;
          end
`endif
          if (data_exit) begin
            addr_q <= addr_d;
            cidx_q <= cidx_q + 16'd1;
`ifdef MM2S_READER_STATUS_EN
            fin_beat_q <= 1'b0;
            sts_q      <= 1'b0;
`endif
            if (last_cmd | stop_req) begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end else begin
              state_q   <= CMD;
              cmd_vld_q <= 1'b1;
            end
          end
        end

        FIN: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_datamover_mm2s_reader.sv
// ---------------------------------------------------------------------------
// tb_datamover_mm2s_reader
//   Directed bench for datamover_mm2s_reader (default parameters: 256 beats
//   per command). A behavioural DataMover model answers each command with
//   256 beats tagged {cmd address, beat index, global sequence}, so the
//   consumer log can be checked for order, loss and tlast placement.
//   Define MM2S_READER_STATUS_EN to also exercise the status stream.
// ---------------------------------------------------------------------------
module tb_datamover_mm2s_reader;

  localparam int BEATS = 256;

  logic         axi_aclk = 1'b0;
  logic         rst, start, abort;
  logic [31:0]  start_addr;
  logic [15:0]  num_cmds;
  logic         axis_cmd_tvalid, axis_cmd_tready;
  logic [71:0]  axis_cmd_tdata;
  logic         axis_data_tvalid, axis_data_tready, axis_data_tlast;
  logic [127:0] axis_data_tdata;
  logic         m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [127:0] m_axis_tdata;
  logic         busy, done, err;
  logic [31:0]  beats_out;
`ifdef MM2S_READER_STATUS_EN
  logic         axis_sts_tvalid, axis_sts_tready;
  logic [7:0]   axis_sts_tdata;
  int           sts_wait = 0;
  int           sts_delay = 2;
  logic [7:0]   sts_byte = 8'h80;
`endif

  always #5 axi_aclk = ~axi_aclk;

  datamover_mm2s_reader dut (
    .axi_aclk(axi_aclk), .rst(rst), .start(start), .start_addr(start_addr),
    .num_cmds(num_cmds), .abort(abort),
    .axis_cmd_tvalid(axis_cmd_tvalid), .axis_cmd_tready(axis_cmd_tready),
    .axis_cmd_tdata(axis_cmd_tdata),
    .axis_data_tvalid(axis_data_tvalid), .axis_data_tready(axis_data_tready),
    .axis_data_tdata(axis_data_tdata), .axis_data_tlast(axis_data_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .busy(busy), .done(done), .err(err), .beats_out(beats_out)
`ifdef MM2S_READER_STATUS_EN
    , .axis_sts_tvalid(axis_sts_tvalid), .axis_sts_tready(axis_sts_tready),
    .axis_sts_tdata(axis_sts_tdata)
`endif
  );

  int tests = 0;
  int fails = 0;

  // DataMover model / consumer / monitor state
  logic [71:0]  cq[$];
  logic [71:0]  clog[$];
  logic [127:0] mlog_d[$];
  logic         mlog_l[$];
  int           rb = 0, inj_beat = -1, done_cnt = 0, out_viol = 0, stall_viol = 0;
  logic [63:0]  r_seq = '0;
  bit           rand_rdy = 1'b0, cmd_rdy_en = 1'b1;
  logic         hs_cmd = 1'b0, hs_dat = 1'b0, stall_prev = 1'b0;
  logic [127:0] stall_data = '0;
  logic [71:0]  cmd_cap = '0;

  function automatic logic [127:0] exp_beat(input logic [31:0] base, input int i);
    return {base + 32'(i / BEATS) * 32'h1000, 32'(i % BEATS), 64'(i)};
  endfunction

  // Inputs change on the falling edge; handshakes are sampled 1 time unit
  // later (settled, before the rising edge that will take them) and the
  // model state advances on the following falling edge.
  initial begin : dm_model
    axis_cmd_tready = 1'b0; axis_data_tvalid = 1'b0; axis_data_tdata = '0;
    axis_data_tlast = 1'b0; m_axis_tready = 1'b0;
`ifdef MM2S_READER_STATUS_EN
    axis_sts_tvalid = 1'b0; axis_sts_tdata = '0;
`endif
    forever begin
      @(negedge axi_aclk);
      if (rst) begin
        cq.delete(); rb = 0; hs_cmd = 1'b0; hs_dat = 1'b0; stall_prev = 1'b0;
`ifdef MM2S_READER_STATUS_EN
        sts_wait = 0;
`endif
      end else begin
        if (hs_cmd) begin
          if (cq.size() != 0) out_viol++;
          cq.push_back(cmd_cap);
          clog.push_back(cmd_cap);
        end
        if (hs_dat) begin
          r_seq++;
          if (rb == BEATS - 1) begin
            rb = 0;
            void'(cq.pop_front());
`ifdef MM2S_READER_STATUS_EN
            sts_wait = sts_delay + 1;
`endif
          end else rb++;
        end
      end
`ifdef MM2S_READER_STATUS_EN
      axis_sts_tvalid = 1'b0;
      if (sts_wait > 0) begin
        sts_wait--;
        if (sts_wait == 0) begin axis_sts_tvalid = 1'b1; axis_sts_tdata = sts_byte; end
      end
`endif
      axis_cmd_tready  = cmd_rdy_en;
      axis_data_tvalid = (cq.size() != 0);
      if (cq.size() != 0) begin
        axis_data_tdata = {cq[0][63:32], 32'(rb), r_seq};
        axis_data_tlast = (rb == BEATS - 1) || (rb == inj_beat);
      end else begin
        axis_data_tdata = '0;
        axis_data_tlast = 1'b0;
      end
      m_axis_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (!rst) begin
        if (stall_prev && (m_axis_tvalid !== 1'b1 || m_axis_tdata !== stall_data)) stall_viol++;
        stall_prev = m_axis_tvalid && !m_axis_tready;
        stall_data = m_axis_tdata;
        hs_cmd  = axis_cmd_tvalid && axis_cmd_tready;
        cmd_cap = axis_cmd_tdata;
        hs_dat  = axis_data_tvalid && axis_data_tready;
        if (m_axis_tvalid && m_axis_tready) begin
          mlog_d.push_back(m_axis_tdata);
          mlog_l.push_back(m_axis_tlast);
        end
        if (done === 1'b1) done_cnt++;
      end
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  task automatic start_run(input logic [31:0] a, input logic [15:0] n);
    clog.delete(); mlog_d.delete(); mlog_l.delete();
    r_seq = '0; done_cnt = 0; out_viol = 0; stall_viol = 0;
    @(negedge axi_aclk); start = 1'b1; start_addr = a; num_cmds = n;
    @(negedge axi_aclk); start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    for (int i = 0; i < limit && done_cnt == 0; i++) @(negedge axi_aclk);
    repeat (5) @(negedge axi_aclk);
  endtask

  task automatic wait_beats(input int n, input int limit);
    for (int i = 0; i < limit && mlog_d.size() < n; i++) @(negedge axi_aclk);
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; abort = 1'b0; start_addr = '0; num_cmds = '0;
    repeat (3) @(negedge axi_aclk);
    #2;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy got %b exp 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL rst_done got %b exp 0", done); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL rst_err got %b exp 0", err); end
    tests++; if (axis_cmd_tvalid !== 1'b0) begin fails++; $display("FAIL rst_cmd_tvalid got %b exp 0", axis_cmd_tvalid); end
    tests++; if (m_axis_tvalid !== 1'b0) begin fails++; $display("FAIL rst_m_tvalid got %b exp 0", m_axis_tvalid); end
    tests++; if (axis_data_tready !== 1'b0) begin fails++; $display("FAIL rst_data_tready got %b exp 0", axis_data_tready); end
    tests++; if (beats_out !== 32'd0) begin fails++; $display("FAIL rst_beats_out got %0d exp 0", beats_out); end
    @(negedge axi_aclk); rst = 1'b0;
    @(negedge axi_aclk);
  endtask

  task automatic test_basic;
    int bad_d, bad_l;
    start_run(32'h0, 16'd2);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy got %b exp 1", busy); end
    wait_done(2000);
    bad_d = 0; bad_l = 0;
    foreach (mlog_d[i]) begin
      if (mlog_d[i] !== exp_beat(32'h0, i)) bad_d++;
      if (mlog_l[i] !== (i == 511)) bad_l++;
    end
    tests++; if (clog.size() !== 2) begin fails++; $display("FAIL basic_ncmd got %0d exp 2", clog.size()); end
    tests++; if (clog.size() > 0 && clog[0] !== 72'h00_00000000_40801000) begin fails++; $display("FAIL basic_cmd0 got %h exp 000000000040801000", clog[0]); end
    tests++; if (clog.size() > 1 && clog[1] !== 72'h01_00001000_40801000) begin fails++; $display("FAIL basic_cmd1 got %h exp 010000100040801000", clog[1]); end
    tests++; if (mlog_d.size() !== 512) begin fails++; $display("FAIL basic_nbeats got %0d exp 512", mlog_d.size()); end
    tests++; if (bad_d !== 0) begin fails++; $display("FAIL basic_order got %0d bad beats exp 0", bad_d); end
    tests++; if (bad_l !== 0) begin fails++; $display("FAIL basic_tlast got %0d misplaced exp 0", bad_l); end
    tests++; if (done_cnt !== 1) begin fails++; $display("FAIL basic_done got %0d pulses exp 1", done_cnt); end
    tests++; if (beats_out !== 32'd512) begin fails++; $display("FAIL basic_beats_out got %0d exp 512", beats_out); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL basic_err got %b exp 0", err); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL basic_idle_busy got %b exp 0", busy); end
    tests++; if (out_viol !== 0) begin fails++; $display("FAIL basic_outstanding got %0d exp 0", out_viol); end
  endtask

  task automatic test_wrap;
    start_run(32'h0FFF_F000, 16'd2);
    wait_done(2000);
    tests++; if (clog.size() > 0 && clog[0] !== 72'h00_0FFFF000_40801000) begin fails++; $display("FAIL wrap_cmd0 got %h exp 000FFFF00040801000", clog[0]); end
    tests++; if (clog.size() !== 2 || clog[1] !== 72'h01_00000000_40801000) begin fails++; $display("FAIL wrap_cmd1 got n=%0d %h exp 010000000040801000", clog.size(), clog[clog.size()-1]); end
    tests++; if (mlog_d.size() !== 512 || mlog_d[256][127:96] !== 32'h0) begin fails++; $display("FAIL wrap_data got n=%0d exp 512 beats, second block at 0", mlog_d.size()); end
    tests++; if (beats_out !== 32'd512) begin fails++; $display("FAIL wrap_beats_out got %0d exp 512", beats_out); end
  endtask

  task automatic test_random_ready;
    int bad_d, bad_l;
    rand_rdy = 1'b1;
    start_run(32'h0000_3000, 16'd3);
    wait_done(6000);
    rand_rdy = 1'b0;
    bad_d = 0; bad_l = 0;
    foreach (mlog_d[i]) begin
      if (mlog_d[i] !== exp_beat(32'h3000, i)) bad_d++;
      if (mlog_l[i] !== (i == 767)) bad_l++;
    end
    tests++; if (mlog_d.size() !== 768) begin fails++; $display("FAIL rnd_nbeats got %0d exp 768", mlog_d.size()); end
    tests++; if (bad_d !== 0) begin fails++; $display("FAIL rnd_order got %0d bad beats exp 0", bad_d); end
    tests++; if (bad_l !== 0) begin fails++; $display("FAIL rnd_tlast got %0d misplaced exp 0", bad_l); end
    tests++; if (stall_viol !== 0) begin fails++; $display("FAIL rnd_stall_stable got %0d changes exp 0", stall_viol); end
    tests++; if (beats_out !== 32'd768) begin fails++; $display("FAIL rnd_beats_out got %0d exp 768", beats_out); end
    tests++; if (done_cnt !== 1) begin fails++; $display("FAIL rnd_done got %0d exp 1", done_cnt); end
  endtask

  task automatic test_abort;
    int bad_l;
    start_run(32'h0001_0000, 16'd4);
    wait_beats(10, 200);
    abort = 1'b1;
    wait_done(2000);
    abort = 1'b0;
    bad_l = 0;
    foreach (mlog_l[i]) if (mlog_l[i] !== (i == 255)) bad_l++;
    tests++; if (clog.size() !== 1) begin fails++; $display("FAIL abort_ncmd got %0d exp 1", clog.size()); end
    tests++; if (mlog_d.size() !== 256) begin fails++; $display("FAIL abort_nbeats got %0d exp 256", mlog_d.size()); end
    tests++; if (bad_l !== 0) begin fails++; $display("FAIL abort_tlast got %0d misplaced exp 0", bad_l); end
    tests++; if (done_cnt !== 1) begin fails++; $display("FAIL abort_done got %0d exp 1", done_cnt); end
    tests++; if (beats_out !== 32'd256) begin fails++; $display("FAIL abort_beats_out got %0d exp 256", beats_out); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL abort_err got %b exp 0", err); end
  endtask

  task automatic test_abort_cmd;
    cmd_rdy_en = 1'b0;
    start_run(32'h0, 16'd3);
    repeat (3) @(negedge axi_aclk);
    #2;
    tests++; if (axis_cmd_tvalid !== 1'b1 || axis_cmd_tdata !== 72'h00_00000000_40801000) begin fails++; $display("FAIL cmdhold got v=%b %h exp v=1 000000000040801000", axis_cmd_tvalid, axis_cmd_tdata); end
    abort = 1'b1;
    wait_done(50);
    abort = 1'b0; cmd_rdy_en = 1'b1;
    tests++; if (done_cnt !== 1) begin fails++; $display("FAIL cmdabort_done got %0d exp 1", done_cnt); end
    tests++; if (clog.size() !== 0 || axis_cmd_tvalid !== 1'b0) begin fails++; $display("FAIL cmdabort_cmd got n=%0d v=%b exp 0 0", clog.size(), axis_cmd_tvalid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL cmdabort_busy got %b exp 0", busy); end
  endtask

  task automatic test_zero_cmds;
    start_run(32'h100, 16'd0);
    wait_done(20);
    tests++; if (done_cnt !== 1) begin fails++; $display("FAIL zero_done got %0d exp 1", done_cnt); end
    tests++; if (clog.size() !== 0) begin fails++; $display("FAIL zero_ncmd got %0d exp 0", clog.size()); end
    tests++; if (beats_out !== 32'd0) begin fails++; $display("FAIL zero_beats_out got %0d exp 0", beats_out); end
  endtask

  task automatic test_start_ignored;
    start_run(32'h2000, 16'd1);
    wait_beats(50, 200);
    start = 1'b1; start_addr = 32'h5000; num_cmds = 16'd3;
    @(negedge axi_aclk); start = 1'b0;
    wait_done(2000);
    tests++; if (clog.size() !== 1 || clog[0] !== 72'h00_00002000_40801000) begin fails++; $display("FAIL ignstart_cmd got n=%0d exp 1 cmd at 2000", clog.size()); end
    tests++; if (beats_out !== 32'd256) begin fails++; $display("FAIL ignstart_beats_out got %0d exp 256", beats_out); end
  endtask

  task automatic test_reset_mid;
    start_run(32'h0, 16'd2);
    wait_beats(20, 200);
    rst = 1'b1;
    @(negedge axi_aclk); #2;
    tests++; if (busy !== 1'b0 || m_axis_tvalid !== 1'b0 || beats_out !== 32'd0) begin fails++; $display("FAIL rstmid got busy=%b tv=%b beats=%0d exp 0 0 0", busy, m_axis_tvalid, beats_out); end
    @(negedge axi_aclk); rst = 1'b0;
    start_run(32'h1000, 16'd1);
    wait_done(2000);
    tests++; if (clog.size() !== 1 || mlog_d.size() !== 256) begin fails++; $display("FAIL rstmid_rerun got cmds=%0d beats=%0d exp 1 256", clog.size(), mlog_d.size()); end
  endtask

`ifdef MM2S_READER_STATUS_EN
  task automatic test_status;
    sts_byte = 8'h40; sts_delay = 20;
    start_run(32'h0, 16'd1);
    wait_beats(256, 1000);
    repeat (10) @(negedge axi_aclk);
    tests++; if (done_cnt !== 0 || busy !== 1'b1) begin fails++; $display("FAIL sts_wait got done=%0d busy=%b exp 0 1", done_cnt, busy); end
    wait_done(100);
    tests++; if (done_cnt !== 1) begin fails++; $display("FAIL sts_done got %0d exp 1", done_cnt); end
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL sts_err got %b exp 1", err); end
    sts_byte = 8'h80; sts_delay = 2;
  endtask
`endif

  task automatic test_tlast_err;
    inj_beat = 99;
    start_run(32'h0, 16'd1);
    wait_done(2000);
    inj_beat = -1;
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL tlerr_err got %b exp 1", err); end
    tests++; if (mlog_d.size() !== 256 || done_cnt !== 1) begin fails++; $display("FAIL tlerr_run got beats=%0d done=%0d exp 256 1", mlog_d.size(), done_cnt); end
    start_run(32'h1000, 16'd1);
    wait_done(2000);
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL tlerr_sticky got %b exp 1", err); end
  endtask

  initial begin : main
    test_reset;
    test_basic;
    test_wrap;
    test_random_ready;
    test_abort;
    test_abort_cmd;
    test_zero_cmds;
    test_start_ignored;
    test_reset_mid;
`ifdef MM2S_READER_STATUS_EN
    test_status;
    test_reset;
`endif
    test_tlast_err;
    test_reset;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/datamover_mm2s_reader.md
DATAMOVER_MM2S_READER -- requirements
Module: datamover_mm2s_reader

Interface
REQ-001 SHALL have parameter BTT_BYTES, default 4096: bytes per MM2S command; multiple of 16, at most 2^23-1.
REQ-002 SHALL have parameter BUF_BASE, default 32'h0000_0000: byte address of the DDR3 ring start.
REQ-003 SHALL have parameter BUF_SIZE, default 32'h1000_0000: ring length in bytes; multiple of BTT_BYTES.
REQ-004 SHALL have port axi_aclk, in, 1: sole clock.
REQ-005 SHALL have port rst, in, 1: synchronous, active-high reset.
REQ-006 SHALL have port start, in, 1: single-cycle pulse that launches a readout.
REQ-007 SHALL have port start_addr, in, 32: first byte address; 16-byte aligned, inside the ring.
REQ-008 SHALL have port num_cmds, in, 16: commands to issue; 0 means no commands.
REQ-009 SHALL have port abort, in, 1: level request to stop.
REQ-010 SHALL have ports axis_cmd_tvalid/tready/tdata, out/in/out, 1/1/72: MM2S command stream.
REQ-011 SHALL have ports axis_data_tvalid/tready/tdata/tlast, in/out/in/in, 1/1/128/1: MM2S read data in.
REQ-012 SHALL have ports m_axis_tvalid/tready/tdata/tlast, out/in/out/out, 1/1/128/1: sample stream to the consumer.
REQ-013 SHALL have ports busy, done, err, out, 1 each: status.
REQ-014 SHALL have port beats_out, out, 32: count of beats delivered since start.

Function
REQ-015 FSM SHALL have states IDLE, CMD, DATA, FIN.
REQ-016 IDLE: start SHALL latch start_addr and num_cmds, then go to CMD, or to FIN if num_cmds==0; start outside IDLE SHALL be ignored.
REQ-017 CMD: axis_cmd_tvalid=1, with tdata[22:0]=BTT_BYTES, [23]=1 (INCR), [29:24]=0, [30]=1 (EOF), [31]=0, [63:32]=current address, [67:64]=command index[3:0], [71:68]=0.
REQ-018 tvalid and tdata SHALL hold stable until tready; the handshake cycle SHALL move the FSM to DATA.
REQ-019 Only one command SHALL be outstanding at a time.
REQ-020 DATA: m_axis_tvalid=axis_data_tvalid and axis_data_tready=m_axis_tready, both combinational with zero latency; tdata passes through; tready SHALL be 0 outside DATA.
REQ-021 m_axis_tlast SHALL be 1 only on the final beat of the final command.
REQ-022 A per-command beat counter SHALL count to BTT_BYTES/16 beats.
REQ-023 If axis_data_tlast disagrees with the final-beat position, err SHALL be set and stay set.
REQ-024 After the final beat, the address SHALL advance by BTT_BYTES.
REQ-025 The address SHALL wrap to BUF_BASE when it reaches BUF_BASE+BUF_SIZE.
REQ-026 After the final beat, the FSM SHALL go to CMD if commands remain, else to FIN.
REQ-027 FIN: done SHALL pulse for exactly 1 cycle, then the FSM SHALL go to IDLE.
REQ-028 busy SHALL be 1 in every state other than IDLE.
REQ-029 abort in CMD before the handshake SHALL go straight to FIN.
REQ-030 abort in DATA SHALL drain the current command fully, then go to FIN; m_axis_tlast SHALL assert on that command's final beat.
REQ-031 beats_out SHALL increment on each m_axis handshake, clear on an accepted start, and wrap at 2^32.
REQ-032 The final data beat and abort arriving in the same cycle SHALL go to FIN.

Reset
REQ-033 rst SHALL force IDLE and zero all counters and the address register.
REQ-034 While rst is asserted, all valid and ready outputs, done, busy and err SHALL be 0.
REQ-035 rst mid-transfer SHALL abandon the transfer without draining; the outstanding DataMover command is the system's responsibility via halt.

Configuration
REQ-036 Macro MM2S_READER_STATUS_EN defined SHALL add ports axis_sts_tvalid (in, 1), axis_sts_tready (out, 1, tied 1) and axis_sts_tdata (in, 8).
REQ-037 With the macro defined, DATA SHALL exit only after both the final beat and a status beat; err SHALL set if sts[7]==0 or any of sts[6:4]==1.
REQ-038 Without the macro, the status ports SHALL be absent and DATA SHALL exit on the final beat alone.

Structure
REQ-039 Package dso_dm_pkg SHALL hold the FSM state enum, command-field bit positions, and constants for INCR, EOF and the 16-byte beat size.
REQ-040 The module SHALL be a single module with no sub-modules; the 72-bit command packer SHALL be a package function.

Verification
REQ-041 Directed test: start_addr=0, num_cmds=2, always-ready responder -> two commands at addresses 0 and 0x1000; 512 beats; tlast on beat 512; done pulses once; beats_out=512.
REQ-042 Directed test: start_addr=0x0FFF_F000, num_cmds=2 -> second command address is 0x0000_0000.
REQ-043 Directed test: m_axis_tready toggling 50% at random -> no beat lost or duplicated; data order preserved; tvalid/tdata stable while stalled.
REQ-044 Directed test: abort on beat 10 of command 1 of 4 -> 256 beats delivered, tlast on beat 256, done pulses, no further command issued.
REQ-045 Directed test: data tlast injected on beat 100 -> err=1, and err stays 1 until rst.
REQ-046 Directed test (MM2S_READER_STATUS_EN defined): status byte 8'h40 -> err=1; done waits for the status beat.
